// File: rtl/trace_pkg.sv
// trace_pkg
// Shared definitions for the sensor trace buffer: the FSM state encoding
// and the default marker byte that stands in for samples while the AES
// done flag is high.
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FULL    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } trace_state_t;

  localparam logic [7:0] MARKER_DEFAULT = 8'hFF;

endpackage

// File: rtl/trace_ram.sv
// trace_ram
// Simple dual-port DEPTH x 8 storage: one write port, one synchronous read
// port. No reset on the array so it maps onto block RAM; contents survive
// reset and successive traces.
// Ports:
//   clk    - common clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address, registered into rdata on the rising edge
//   rdata  - read data, one cycle after raddr
module trace_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sensor_trace_buffer.sv
// sensor_trace_buffer
// Captures DEPTH consecutive TDC sensor samples starting on the AES
// data-ready strobe, then streams them to a UART transmitter one byte at a
// time, in address order.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | waiting for arm_i
// ARMED      | waiting for trig_i; the trigger cycle writes address 0
// CAPTURE    | one write per cycle until address DEPTH-1 is written
// FULL       | trace held, waiting for send_i
// SEND       | present buffered byte, pulse tx_start_o
// WAIT_TX    | wait for tx_done_i, then next byte or back to IDLE
//
// Ports:
//   clk, rstn      - clock, async active-low reset
//   arm_i          - arm pulse (IDLE only)
//   trig_i         - capture start (ARMED only)
//   sample_i       - sensor byte, valid every cycle
//   done_i         - when high, MARKER is stored instead of sample_i
//   send_i         - readout request (FULL only)
//   tx_start_o     - one-cycle strobe per byte to the UART
//   tx_byte_o      - byte to transmit, held until tx_done_i
//   tx_done_i      - UART byte-complete pulse (WAIT_TX only)
//   busy_o, full_o - status
module sensor_trace_buffer
  import trace_pkg::*;
#(
  parameter int         DEPTH  = 2048,
  parameter int         AW     = 11,
  parameter logic [7:0] MARKER = MARKER_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       arm_i,
  input  logic       trig_i,
  input  logic [7:0] sample_i,
  input  logic       done_i,
  input  logic       send_i,
  output logic       tx_start_o,
  output logic [7:0] tx_byte_o,
  input  logic       tx_done_i,
  output logic       busy_o,
  output logic       full_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  trace_state_t  state;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [7:0]    rd_data;

  // The trigger cycle itself is a write, so capture has no latency.
  assign wr_en   = ((state == ST_ARMED) && trig_i) || (state == ST_CAPTURE);
  assign wr_data = done_i ? MARKER : sample_i;

  // The RAM needs its address a cycle ahead of SEND: on the finishing
  // tx_done_i the next address is issued so rd_data is ready in SEND.
  assign rd_addr = ((state == ST_WAIT_TX) && tx_done_i) ? raddr + AW'(1) : raddr;

  trace_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(waddr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      waddr      <= '0;
      raddr      <= '0;
      tx_start_o <= 1'b0;
      tx_byte_o  <= 8'h00;
      busy_o     <= 1'b0;
      full_o     <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // trig_i in the arming cycle is deliberately not honoured.
          if (arm_i) begin
            state  <= ST_ARMED;
            waddr  <= '0;
            raddr  <= '0;
            busy_o <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (trig_i) begin
            state <= ST_CAPTURE;
            waddr <= waddr + AW'(1);
          end
        end
        ST_CAPTURE: begin
          // Natural AW-bit wrap returns waddr to 0 on the final write.
          waddr <= waddr + AW'(1);
          if (waddr == LAST) begin
            state  <= ST_FULL;
            full_o <= 1'b1;
          end
        end
        ST_FULL: begin
          if (send_i) begin
            state  <= ST_SEND;
            full_o <= 1'b0;
          end
        end
        ST_SEND: begin
          tx_byte_o  <= rd_data;
          tx_start_o <= 1'b1;
          state      <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (tx_done_i) begin
            raddr <= raddr + AW'(1);
            if (raddr == LAST) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          full_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sensor_trace_buffer.md
SENSOR_TRACE_BUFFER -- requirements
Module: sensor_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 2048: number of 8-bit samples captured per trace; a power of two.
REQ-002 Parameter AW, default 11: address width; log2(DEPTH).
REQ-003 Parameter MARKER, default 8'hFF: byte stored in place of a sample when done_i is high.
REQ-004 clk  in  1  single clock; sample capture and readout both run on its rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 arm_i  in  1  one-cycle pulse; arms the buffer for the next trigger.
REQ-007 trig_i  in  1  capture start; the AES data-ready strobe.
REQ-008 sample_i  in  8  decoded TDC sensor value, valid every cycle.
REQ-009 done_i  in  1  AES done flag; while high, MARKER replaces sample_i in the buffer.
REQ-010 send_i  in  1  one-cycle pulse; requests readout of the captured trace.
REQ-011 tx_start_o  out  1  one-cycle strobe to the UART transmitter.
REQ-012 tx_byte_o  out  8  byte to transmit; stable from tx_start_o until tx_done_i.
REQ-013 tx_done_i  in  1  one-cycle UART byte-complete pulse.
REQ-014 busy_o  out  1  high in every state except IDLE.
REQ-015 full_o  out  1  high in FULL only.

Function
REQ-016 The state machine SHALL have states IDLE, ARMED, CAPTURE, FULL, SEND and WAIT_TX.
- IDLE -> ARMED on arm_i.
- ARMED -> CAPTURE on trig_i.
- CAPTURE -> FULL after DEPTH writes.
- FULL -> SEND on send_i.
- SEND -> WAIT_TX unconditionally.
- WAIT_TX -> SEND on tx_done_i when bytes remain.
- WAIT_TX -> IDLE on tx_done_i after the last byte.
REQ-017 In the cycle trig_i is sampled high in ARMED, the block SHALL write sample_i (or MARKER) to address 0; capture is zero-latency.
REQ-018 In CAPTURE, each cycle SHALL write one byte at the write address and increment it; the write at address DEPTH-1 SHALL be the last, and the next state is FULL.
REQ-019 The byte written SHALL be MARKER when done_i=1, and sample_i otherwise; done_i has priority.
REQ-020 The write address SHALL wrap to 0 in the cycle of the DEPTH-1 write; no write SHALL occur outside ARMED+trig_i or CAPTURE.
REQ-021 In SEND, the block SHALL present buffer[read address] on tx_byte_o and pulse tx_start_o for exactly one cycle.
- The buffer is synchronous-read RAM; the read address is issued one cycle earlier.
- tx_byte_o is registered and held until tx_done_i.
REQ-022 On tx_done_i in WAIT_TX, the read address SHALL increment, wrapping from DEPTH-1 to 0; exactly DEPTH bytes are sent, in address order.
REQ-023 tx_done_i outside WAIT_TX SHALL be ignored.
REQ-024 arm_i outside IDLE SHALL be ignored.
REQ-025 trig_i outside ARMED SHALL be ignored.
REQ-026 send_i outside FULL SHALL be ignored.
REQ-027 If arm_i and trig_i are high in the same cycle in IDLE, the block SHALL go to ARMED only; capture waits for a later trig_i.
REQ-028 Buffer contents SHALL persist across traces and reset; only the addresses and state are cleared.

Reset
REQ-029 When rstn is low, the block SHALL asynchronously set:
- state = IDLE and both addresses = 0;
- tx_start_o = 0, tx_byte_o = 8'h00, busy_o = 0, full_o = 0.
REQ-030 Reset asserted mid-CAPTURE or mid-SEND SHALL abort the trace, with no further tx_start_o after rstn rises until a new arm/trig/send sequence completes.
REQ-031 The RAM array SHALL have no reset, so it infers block RAM.

Structure
REQ-032 State encodings and the default MARKER value SHALL live in a shared package, trace_pkg, for reuse by the main FSM.
REQ-033 The storage SHALL be one sub-module, trace_ram: simple dual-port, one write port and one synchronous read port, DEPTH x 8.
REQ-034 The block SHALL contain no clock-domain crossing; the integrator places it on the sensor/UART common clock.

Verification
REQ-035 Run arm_i, then trig_i with sample_i = counter 0..2047 and done_i=0, then send_i with tx_done_i returned 10 cycles after each tx_start_o.
- Required: 2048 tx_start_o pulses with bytes 0x00..0xFF repeating, then IDLE.
REQ-036 Hold done_i=1 for capture cycles 100..109.
- Required: bytes 100..109 read back as 0xFF; all others equal the samples.
REQ-037 Drive trig_i in IDLE, send_i in ARMED, and arm_i in CAPTURE.
- Required: no state change and no write in each case.
REQ-038 Pulse arm_i and trig_i together in IDLE.
- Required: state ARMED; no write.
- A later trig_i starts capture at address 0.
REQ-039 Assert rstn=0 at readout byte 500.
- Required: all outputs at reset values immediately.
- No tx_start_o until a new sequence; a re-armed capture overwrites from address 0.
REQ-040 Issue a spurious tx_done_i in SEND and a second send_i in WAIT_TX.
- Required: byte count unchanged at 2048 and order preserved.
